stc_a_nz_encoder: RTL and testbench

Row-wise nonzero encoder for the unstructured sparse tensor core. It accepts one dense row of matrix A, with K elements, and compresses its nonzero elements into beats of up to N_PE (column index, value) pairs. The index half of each beat feeds the `in_cols` port of `stc_B_DN`, which uses it to select the matching rows of B. The value half is forwarded to the PE multipliers. A valid/ready handshake on both sides lets the block stall against the B distribution network and the PE array.

---
 rtl/stc_a_nz_encoder.sv | 144 ++++++++++++++
 tb/tb_stc_a_nz_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stc_a_nz_encoder.sv
// Row-wise nonzero encoder: compresses one dense A row into beats of up to N_PE (column, value) pairs.
// Optional macro STC_A_ENC_SKIP_EMPTY_EN: all-zero rows are absorbed without emitting a beat.
module stc_a_nz_encoder #(
   parameter int K       = 16,
   parameter int DW_DATA = 16,
   parameter int DW_COL  = 4,
   parameter int N_PE    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [K*DW_DATA-1:0]    in_a,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_PE*DW_COL-1:0]  out_cols,
   output logic [N_PE*DW_DATA-1:0] out_a,
   output logic [N_PE-1:0]         out_mask,
   output logic                    out_last
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                   state, state_nxt;
   logic [K*DW_DATA-1:0]     row_buf;
   logic [K-1:0]             rem_mask;
   logic [K-1:0]             row_nz;
   logic                     ready_nxt, load_beat, drop_beat;
   logic                     accept, fire;

   logic [K-1:0]             src_mask;
   logic [K*DW_DATA-1:0]     src_data;
   logic [N_PE*DW_COL-1:0]   b_cols;
   logic [N_PE*DW_DATA-1:0]  b_a;
   logic [N_PE-1:0]          b_mask;
   logic [K-1:0]             b_used;
   logic                     b_last;

   assign accept = in_valid && in_ready;
   assign fire   = out_valid && out_ready;

   always_comb begin
      for (int i = 0; i < K; i++)
         row_nz[i] = |in_a[i*DW_DATA +: DW_DATA];
   end

   // rem_mask holds the indices not yet placed on the outputs, so a new beat is built
   // either from the incoming row (IDLE) or from what is left of the buffered row (EMIT).
   assign src_mask = (state == IDLE) ? row_nz : rem_mask;
   assign src_data = (state == IDLE) ? in_a   : row_buf;

   always_comb begin
      int unsigned lane;
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      b_cols = '0;
      b_a    = '0;
      b_mask = '0;
      b_used = '0;
      lane   = 0;
      for (int i = 0; i < K; i++) begin
         if (src_mask[i] && lane < N_PE) begin
            b_cols[lane*DW_COL +: DW_COL]   = DW_COL'(i);
            b_a[lane*DW_DATA +: DW_DATA]    = src_data[i*DW_DATA +: DW_DATA];
            b_mask[lane]                    = 1'b1;
            b_used[i]                       = 1'b1;
            lane                            = lane + 1;
         end
      end
      b_last = ((src_mask & ~b_used) == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ready_nxt = 1'b0;
      load_beat = 1'b0;
      drop_beat = 1'b0;
      unique case (state)
         IDLE: begin
            ready_nxt = 1'b1;
            if (accept) begin
`ifdef STC_A_ENC_SKIP_EMPTY_EN
               if (row_nz != '0) begin
                  load_beat = 1'b1;
                  ready_nxt = 1'b0;
                  state_nxt = EMIT;
               end
`else
               load_beat = 1'b1;
               ready_nxt = 1'b0;
               state_nxt = EMIT;
`endif
            end
         end
         EMIT: begin
            if (fire) begin
               if (out_last) begin
                  drop_beat = 1'b1;
                  ready_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  load_beat = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_mask  <= '0;
         out_cols  <= '0;
         out_a     <= '0;
         rem_mask  <= '0;
      end else begin
         in_ready <= ready_nxt;
         if (load_beat) begin
            out_valid <= 1'b1;
            out_last  <= b_last;
            out_mask  <= b_mask;
            out_cols  <= b_cols;
            out_a     <= b_a;
            rem_mask  <= src_mask & ~b_used;
         end else if (drop_beat) begin
            out_valid <= 1'b0;
         end
      end
   end

   // NOTE: the row buffer is deliberately not reset; rem_mask gates every read of it.
   always_ff @(posedge clk) begin
      if (accept) row_buf <= in_a;
   end

endmodule

// File: tb/tb_stc_a_nz_encoder.sv
// Scoreboard bench for stc_a_nz_encoder: stimulus pushes hand-computed beats, a negedge monitor pops and compares.
module tb_stc_a_nz_encoder;
   localparam int K = 16, DW_DATA = 16, DW_COL = 4, N_PE = 4;

   logic                    clk = 1'b0;
   logic                    reset = 1'b0;
   logic                    in_valid = 1'b0;
   logic                    in_ready;
   logic [K*DW_DATA-1:0]    in_a = '0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic [N_PE*DW_COL-1:0]  out_cols;
   logic [N_PE*DW_DATA-1:0] out_a;
   logic [N_PE-1:0]         out_mask;
   logic                    out_last;

   typedef struct packed {
      logic [15:0] cols;
      logic [63:0] a;
      logic [3:0]  mask;
      logic        last;
   } beat_t;

   beat_t exp_q[$];
   int    n_cmp  = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   stc_a_nz_encoder #(.K(K), .DW_DATA(DW_DATA), .DW_COL(DW_COL), .N_PE(N_PE)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_cols(out_cols), .out_a(out_a), .out_mask(out_mask), .out_last(out_last)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: pops one expected beat per handshake and checks that stalled beats hold.
   beat_t snap;
   bit    have_snap = 1'b0;
   always @(negedge clk) begin
      beat_t act, e;
      act = {out_cols, out_a, out_mask, out_last};
      if (reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_beat: actual=%h required=none", act);
         end else begin
            e = exp_q.pop_front();
            check("beat", 128'(act), 128'(e));
         end
         have_snap = 1'b0;
      end else if (reset && out_valid && !out_ready) begin
         if (have_snap) check("stall_hold", 128'(act), 128'(snap));
         snap      = act;
         have_snap = 1'b1;
      end else begin
         have_snap = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [K*DW_DATA-1:0] dense_row();
      logic [K*DW_DATA-1:0] r;
      for (int i = 0; i < K; i++) r[i*DW_DATA +: DW_DATA] = 16'(i + 1);
      return r;
   endfunction

   function automatic logic [K*DW_DATA-1:0] sparse_row();
      logic [K*DW_DATA-1:0] r;
      r = '0;
      r[2*16 +: 16]  = 16'h000A;
      r[7*16 +: 16]  = 16'h000B;
      r[9*16 +: 16]  = 16'h000C;
      r[15*16 +: 16] = 16'h000D;
      r[11*16 +: 16] = 16'h000E;
      return r;
   endfunction

   task automatic push_dense();
      for (int b = 0; b < 4; b++) begin
         beat_t e;
         e = '0;
         for (int p = 0; p < 4; p++) begin
            e.cols[p*4 +: 4]  = 4'(4*b + p);
            e.a[p*16 +: 16]   = 16'(4*b + p + 1);
         end
         e.mask = 4'b1111;
         e.last = (b == 3);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_sparse();
      beat_t e;
      e = '{cols: {4'd11, 4'd9, 4'd7, 4'd2},
            a: {16'h000E, 16'h000C, 16'h000B, 16'h000A},
            mask: 4'b1111, last: 1'b0};
      exp_q.push_back(e);
      e = '{cols: {4'd0, 4'd0, 4'd0, 4'd15},
            a: {16'h0000, 16'h0000, 16'h0000, 16'h000D},
            mask: 4'b0001, last: 1'b1};
      exp_q.push_back(e);
   endtask

   // Presents one row as soon as in_ready is seen; returns one time unit after the accepting edge.
   task automatic send_row(input logic [K*DW_DATA-1:0] row, input bit empty);
      int n;
      n = 0;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      check("send_wait_in_ready", 128'(n < 200), 128'(1));
      in_a     = row;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
`ifdef STC_A_ENC_SKIP_EMPTY_EN
      if (empty) begin
         check("empty_skip_ready", 128'(in_ready), 128'(1));
         check("empty_skip_no_beat", 128'(out_valid), 128'(0));
      end else begin
         check("first_beat_latency", 128'(out_valid), 128'(1));
      end
`else
      check("first_beat_latency", 128'({out_valid, in_ready, empty & out_last}), 128'({2'b10, empty}));
`endif
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         tick();
         n++;
      end
      check("drain_timeout", 128'(n < 200), 128'(1));
   endtask

   initial begin
      int n;
      // Reset held for two cycles with a row offered
      reset    = 1'b0;
      in_valid = 1'b1;
      in_a     = dense_row();
      tick();
      check("reset_outputs_c0", 128'({in_ready, out_valid, out_last, out_mask, out_cols, out_a}), 128'(0));
      tick();
      check("reset_outputs_c1", 128'({in_ready, out_valid, out_last, out_mask, out_cols, out_a}), 128'(0));
      reset = 1'b1;
      @(negedge clk);
      check("ready_low_at_release", 128'({in_ready, out_valid}), 128'(0));
      tick();
      check("ready_one_cycle_after", 128'({in_ready, out_valid}), 128'(2'b10));
      in_valid = 1'b0;
      tick();
      check("nothing_accepted_in_reset", 128'({in_ready, out_valid}), 128'(2'b10));

      // Dense row, full throughput
      push_dense();
      send_row(dense_row(), 1'b0);
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("dense_ready_return_cycles", 128'(n), 128'(4));
      drain();

      // Sparse row
      push_sparse();
      send_row(sparse_row(), 1'b0);
      drain();

      // Backpressure on beat 1 for three cycles
      push_dense();
      send_row(dense_row(), 1'b0);
      tick();
      out_ready = 1'b0;
      tick();
      tick();
      tick();
      out_ready = 1'b1;
      drain();

      // Two all-zero rows back to back
`ifndef STC_A_ENC_SKIP_EMPTY_EN
      exp_q.push_back('{cols: 16'h0, a: 64'h0, mask: 4'b0, last: 1'b1});
      exp_q.push_back('{cols: 16'h0, a: 64'h0, mask: 4'b0, last: 1'b1});
`endif
      send_row('0, 1'b1);
      send_row('0, 1'b1);
      drain();

      // Reset while beat 2 of a dense row is on the outputs
      push_dense();
      send_row(dense_row(), 1'b0);
      tick();
      tick();
      check("mid_row_before_reset", 128'({out_valid, out_cols}), 128'({1'b1, 4'd11, 4'd10, 4'd9, 4'd8}));
      reset = 1'b0;
      tick();
      check("mid_row_reset_drops", 128'({out_valid, in_ready}), 128'(0));
      exp_q.delete();
      reset = 1'b1;
      tick();
      check("mid_row_after_release", 128'({out_valid, in_ready}), 128'(2'b01));
      push_sparse();
      send_row(sparse_row(), 1'b0);
      drain();

      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
